// File: rtl/alu_arb_pkg.sv
// Shared types, flag layout and flag computation for the arbitrated ALU.
package alu_arb_pkg;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100
    } alu_op_e;

    localparam int unsigned FLG_ZERO  = 0;
    localparam int unsigned FLG_NEG   = 1;
    localparam int unsigned FLG_CARRY = 2;
    localparam int unsigned FLG_OVF   = 3;

    // Status flags for one ALU operation; carry/ovf only meaningful for add/sub.
    function automatic logic [3:0] alu_flags(input logic [7:0] in0,
                                             input logic [7:0] in1,
                                             input logic [2:0] op,
                                             input logic [7:0] result);
        logic [8:0] sum;
        logic [3:0] f;
        f   = '0;
        sum = {1'b0, in0} + {1'b0, in1};
        f[FLG_ZERO] = (result == '0);
        f[FLG_NEG]  = result[7];
        case (alu_op_e'(op))
            OP_ADD: begin
                f[FLG_CARRY] = sum[8];
                f[FLG_OVF]   = (in0[7] == in1[7]) && (result[7] != in0[7]);
            end
            OP_SUB: begin
                f[FLG_CARRY] = (in0 < in1);
                f[FLG_OVF]   = (in0[7] != in1[7]) && (result[7] != in0[7]);
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU: add, sub, and, or, xor; unused opcodes yield 0.
module alu
    import alu_arb_pkg::*;
(
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic [2:0] op_i,
    output logic [7:0] y_o
);

    // Opcode decode with 8-bit wrap-around arithmetic.
    always_comb begin
        y_o = '0;
        case (alu_op_e'(op_i))
            OP_ADD:  y_o = a_i + b_i;
            OP_SUB:  y_o = a_i - b_i;
            OP_AND:  y_o = a_i & b_i;
            OP_OR:   y_o = a_i | b_i;
            OP_XOR:  y_o = a_i ^ b_i;
            default: y_o = '0;
        endcase
    end

endmodule

// File: rtl/alu_rr_arbiter_rr_pick.sv
// Round-robin pick: first set request at or after ptr_i, wrapping modulo NREQ.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [IDW-1:0]  grant_o,
    output logic            any_o
);

    logic [IDW-1:0] idx;
    logic           found;

    // Walk NREQ positions from the pointer; the first valid one wins.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = ptr_i;
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (!found && req_i[idx]) begin
                grant_o = idx;
                found   = 1'b1;
            end
            idx = (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
        any_o = found;
    end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between NREQ requesters via round-robin arbitration and
// registers the result with flags into a single-entry response slot.
module alu_rr_arbiter
    import alu_arb_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2,
    parameter int unsigned CNTW = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*8-1:0] req_in0,
    input  logic [NREQ*8-1:0] req_in1,
    input  logic [NREQ*3-1:0] req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [7:0]        rsp_out,
    output logic [3:0]        rsp_flags,
    output logic [CNTW-1:0]   op_count
);

    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [7:0]      rsp_out_q, rsp_out_d;
    logic [3:0]      rsp_flags_q, rsp_flags_d;
    logic [CNTW-1:0] cnt_q, cnt_d;

    logic [IDW-1:0]  grant;
    logic            any_valid;
    logic            can_load;
    logic            fire;
    logic [7:0]      in0_sel, in1_sel, alu_y;
    logic [2:0]      op_sel;

    rr_pick #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_pick (
        .req_i   (req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .any_o   (any_valid)
    );

    alu u_alu (
        .a_i  (in0_sel),
        .b_i  (in1_sel),
        .op_i (op_sel),
        .y_o  (alu_y)
    );

    assign can_load = !rsp_valid_q || rsp_ready;
    assign fire     = any_valid && can_load && !rst;

    // Steer the winner's operands to the ALU and raise its ready bit.
    always_comb begin
        in0_sel   = '0;
        in1_sel   = '0;
        op_sel    = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                in0_sel      = req_in0[8*i +: 8];
                in1_sel      = req_in1[8*i +: 8];
                op_sel       = req_op[3*i +: 3];
                req_ready[i] = fire;
            end
        end
    end

    // Response slot: load on fire, drain on handshake, otherwise hold.
    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_out_d   = rsp_out_q;
        rsp_flags_d = rsp_flags_q;
        cnt_d       = cnt_q;
        if (fire) begin
            rsp_valid_d = 1'b1;
            rsp_id_d    = grant;
            rsp_out_d   = alu_y;
            rsp_flags_d = alu_flags(in0_sel, in1_sel, op_sel, alu_y);
            rr_ptr_d    = (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
        if (rsp_valid_q && rsp_ready && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_out_q   <= '0;
            rsp_flags_q <= '0;
            cnt_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_out_q   <= rsp_out_d;
            rsp_flags_q <= rsp_flags_d;
            cnt_q       <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_out   = rsp_out_q;
    assign rsp_flags = rsp_flags_q;
    assign op_count  = cnt_q;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Scoreboard bench for alu_rr_arbiter: a reference model predicts grants and
// results, a monitor compares each presented response against the queue.
module tb_alu_rr_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*8-1:0] req_in0;
    logic [NREQ*8-1:0] req_in1;
    logic [NREQ*3-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [7:0]        rsp_out;
    logic [3:0]        rsp_flags;
    logic [CNTW-1:0]   op_count;

    logic [7:0]        s_in0 [NREQ];
    logic [7:0]        s_in1 [NREQ];
    logic [2:0]        s_op  [NREQ];
    logic [NREQ-1:0]   s_valid;

    typedef struct {
        int id;
        int out;
        int flags;
    } rsp_t;

    rsp_t            sb[$];
    int              n_checks = 0;
    int              n_fail   = 0;
    int              m_ptr    = 0;
    int              m_valid  = 0;
    int              m_cnt    = 0;
    logic [NREQ-1:0] m_fire_vec = '0;

    always #5 clk = ~clk;

    alu_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW),
        .CNTW (CNTW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in0   (req_in0),
        .req_in1   (req_in1),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_out   (rsp_out),
        .rsp_flags (rsp_flags),
        .op_count  (op_count)
    );

    // Pack per-requester stimulus into the flat DUT buses.
    always_comb begin
        req_valid = s_valid;
        req_in0   = '0;
        req_in1   = '0;
        req_op    = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_in0[8*i +: 8] = s_in0[i];
            req_in1[8*i +: 8] = s_in1[i];
            req_op[3*i +: 3]  = s_op[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU in plain integer arithmetic; flags as {ovf,carry,neg,zero}.
    task automatic ref_alu(input int a, input int b, input int op, output int res, output int flags);
        int r, ua, ub, c, v, z, n;
        ua = a & 255;
        ub = b & 255;
        c  = 0;
        v  = 0;
        case (op)
            0: begin r = a + b; c = (ua + ub > 255) ? 1 : 0; v = (r > 127 || r < -128) ? 1 : 0; end
            1: begin r = a - b; c = (ua < ub) ? 1 : 0;       v = (r > 127 || r < -128) ? 1 : 0; end
            2: r = ua & ub;
            3: r = ua | ub;
            4: r = ua ^ ub;
            default: r = 0;
        endcase
        res   = r & 255;
        z     = (res == 0) ? 1 : 0;
        n     = (res >= 128) ? 1 : 0;
        flags = v * 8 + c * 4 + n * 2 + z;
    endtask

    // Reference model: predict ready/grant, count handshakes, push results.
    initial begin
        int              w, k, i, res, flg;
        logic [NREQ-1:0] er;
        bit              can_load;
        rsp_t            e;
        forever begin
            @(posedge clk);
            #3;
            if (rst) begin
                m_ptr      = 0;
                m_valid    = 0;
                m_cnt      = 0;
                m_fire_vec = '0;
            end else begin
                w        = -1;
                er       = '0;
                can_load = (m_valid == 0) || (rsp_ready == 1'b1);
                for (k = 0; k < NREQ; k++) begin
                    i = (m_ptr + k) % NREQ;
                    if (w < 0 && s_valid[i]) w = i;
                end
                if (w >= 0 && can_load) er[w] = 1'b1;
                chk("req_ready", 32'(req_ready), 32'(er));
                chk("op_count", 32'(op_count), m_cnt);
                if (m_valid != 0 && rsp_ready && m_cnt < 65535) m_cnt++;
                if (er != '0) begin
                    ref_alu(int'($signed(s_in0[w])), int'($signed(s_in1[w])), int'(s_op[w]), res, flg);
                    e.id    = w;
                    e.out   = res;
                    e.flags = flg;
                    sb.push_back(e);
                    m_ptr   = (w + 1) % NREQ;
                    m_valid = 1;
                end else if (rsp_ready) begin
                    m_valid = 0;
                end
                m_fire_vec = er;
            end
        end
    end

    // Monitor: whenever a response is presented, compare it with the queue head.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                chk("rst_rsp_valid", 32'(rsp_valid), 0);
                chk("rst_op_count", 32'(op_count), 0);
                chk("rst_req_ready", 32'(req_ready), 0);
                sb.delete();
            end else begin
                chk("rsp_valid", 32'(rsp_valid), (sb.size() > 0) ? 1 : 0);
                if (rsp_valid === 1'b1 && sb.size() > 0) begin
                    chk("rsp_id", 32'(rsp_id), sb[0].id);
                    chk("rsp_out", 32'(rsp_out), sb[0].out);
                    chk("rsp_flags", 32'(rsp_flags), sb[0].flags);
                    if (rsp_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit v, input logic [7:0] a, input logic [7:0] b,
                           input logic [2:0] o);
        s_valid[i] = v;
        s_in0[i]   = a;
        s_in1[i]   = b;
        s_op[i]    = o;
    endtask

    // Requesters hold valid/operands until accepted; new ops are random.
    task automatic rand_cycle(input bit all_valid, input int ready_pct);
        for (int i = 0; i < NREQ; i++) begin
            if (!s_valid[i] || m_fire_vec[i]) begin
                s_valid[i] = all_valid ? 1'b1 : 1'($urandom_range(0, 1));
                s_in0[i]   = 8'($urandom);
                s_in1[i]   = 8'($urandom);
                s_op[i]    = 3'($urandom_range(0, 7));
            end
        end
        rsp_ready = ($urandom_range(0, 99) < ready_pct);
        next();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] da [7];
        logic [7:0] db [7];
        logic [2:0] dop [7];
        da  = '{8'd127, 8'd4,  8'h55, 8'h55, 8'h55, 8'h55, 8'h55};
        db  = '{8'd1,   8'd12, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        dop = '{3'd0,   3'd1,  3'd2,  3'd3,  3'd4,  3'd5,  3'd7};

        rst       = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 8'h00, 8'h00, 3'd0);
        next();
        next();
        rst = 1'b0;

        // Single op: 12 + (-4) from requester 0.
        rsp_ready = 1'b1;
        set_req(0, 1'b1, 8'd12, 8'hFC, 3'd0);
        next();
        s_valid = '0;
        next();
        next();

        // Flag corner cases and logic/illegal opcodes, one per cycle.
        for (int t = 0; t < 7; t++) begin
            set_req(0, 1'b1, da[t], db[t], dop[t]);
            next();
        end
        s_valid = '0;
        next();
        next();

        // Continuous round-robin with no backpressure.
        repeat (12) rand_cycle(1'b1, 100);

        // Backpressure with all requesters valid, then release.
        repeat (6) rand_cycle(1'b1, 0);
        repeat (4) rand_cycle(1'b1, 100);

        // Random traffic with random backpressure.
        repeat (300) rand_cycle(1'b0, 70);

        // Reset while a response is held under backpressure.
        repeat (3) rand_cycle(1'b1, 0);
        rst = 1'b1;
        next();
        s_valid = '0;
        next();
        set_req(2, 1'b1, 8'd3, 8'd5, 3'd0);
        set_req(0, 1'b1, 8'd9, 8'd2, 3'd1);
        rsp_ready = 1'b1;
        rst       = 1'b0;
        next();
        repeat (20) rand_cycle(1'b0, 80);

        // Drain.
        s_valid   = '0;
        rsp_ready = 1'b1;
        repeat (4) next();
        chk("drain_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_rr_arbiter.md
Name: alu_rr_arbiter

Overview:
Shares one instance of the team's combinational 8-bit `alu` between NREQ requesters. Each requester presents an operation with a valid/ready handshake. A round-robin arbiter grants one requester per cycle and drives the ALU with that requester's operands. The ALU result is captured, with status flags, into a single-entry response register that has its own valid/ready handshake.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester-ID width; must equal max(1, $clog2(NREQ))
CNTW, 16, width of the completed-operation counter

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
req_valid  input  NREQ  per-requester operation valid
req_ready  output  NREQ  per-requester accept; one-hot or zero
req_in0  input  NREQ*8  signed operand 0; requester i is at [8i+7:8i]
req_in1  input  NREQ*8  signed operand 1, same packing
req_op  input  NREQ*3  opcode; requester i is at [3i+2:3i]
rsp_valid  output  1  response register holds a result
rsp_ready  input  1  consumer accepts the response
rsp_id  output  IDW  index of the requester that produced the result
rsp_out  output  8  signed ALU result
rsp_flags  output  4  {ovf, carry, neg, zero}
op_count  output  CNTW  completed handshakes, saturating

Behaviour:
- Reset (async, active-high): rsp_valid=0, rsp_id=0, rsp_out=0, rsp_flags=0, op_count=0, rr_ptr=0. While rst is high, req_ready=0.
- can_load = !rsp_valid | rsp_ready. The output register drains and reloads in the same cycle, giving a throughput of one op per cycle.
- Arbitration (combinational):
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ; the first set bit is the winner.
  - req_ready[winner] = can_load. All other req_ready bits are 0.
  - If no request is valid, or can_load=0, req_ready=0.
  - req_ready does not depend on rsp_valid alone: it depends on can_load only.
- Fire = req_valid[w] & req_ready[w]. On fire, at the next clock edge:
  - rsp_out = alu(in0,in1,op) of the winner; rsp_id = w; rsp_flags computed as below; rsp_valid = 1.
  - rr_ptr = (w+1) mod NREQ. The winner therefore gets lowest priority next cycle.
- No fire, but rsp_ready & rsp_valid: rsp_valid=0. Data registers hold their previous values.
- No fire and rsp_valid & !rsp_ready: all response outputs hold stable. A valid response is never overwritten.
- rr_ptr changes only on fire.
- Latency: 1 cycle from request fire to rsp_valid.
- Requesters hold valid and operands stable until ready. The block neither checks nor samples this outside the fire cycle.
- ALU semantics (fixed by the existing alu):
  - 000 add; 001 sub (in0-in1); 010 and; 011 or; 100 xor; 101–111 produce 0.
  - 8-bit wrap-around result.
- Flags:
  - zero = (result==0).
  - neg = result[7].
  - carry is defined for add/sub only: add → carry out of the 9-bit unsigned sum; sub → borrow, i.e. unsigned in0<in1. carry=0 for all other ops.
  - ovf is defined for add/sub only: signed overflow, meaning the operand signs produce a result of the wrong sign. ovf=0 for all other ops.
  - Illegal ops: result=0, so zero=1 and all other flags are 0.
- op_count increments on each response handshake (rsp_valid & rsp_ready) and saturates at all-ones.
- A simultaneous fire and response handshake in one cycle: op_count+1, and the register loads the new result.
- Reset asserted mid-operation: any in-flight response is discarded immediately (async). Arbitration restarts from requester 0.

Decomposition:
- Package alu_arb_pkg holds:
  - alu_op_e enum: OP_ADD=3'b000, OP_SUB, OP_AND, OP_OR, OP_XOR.
  - Flag bit-index constants FLG_ZERO=0, FLG_NEG=1, FLG_CARRY=2, FLG_OVF=3.
  - Function alu_flags(in0,in1,op,result) returning 4 bits.
- One sub-module, rr_pick: parameterised NREQ; inputs req vector and ptr; outputs grant index and any_valid. The top level instantiates rr_pick and the existing alu.

Test Plan:
1. Single op. After reset, req 0 presents in0=12, in1=-4, op=000, with rsp_ready=1. Required: req_ready[0]=1; next cycle rsp_valid=1, rsp_out=8, id=0, flags=0b0100 (carry=1); op_count=1.
2. Round-robin, NREQ=4. All four requesters valid continuously, rsp_ready=1. Required: grants in order 0,1,2,3,0,… one per cycle; rsp_id follows one cycle later with no bubbles.
3. Backpressure. rsp_ready=0 with all requesters valid. Required: one fire, then req_ready=0 and the response held stable for 5 cycles. When rsp_ready=1, the same-cycle reload fires the next requester in rotation.
4. Overflow and borrow flags.
   - in0=127, in1=1, op=000 → out=-128, flags ovf=1, neg=1, carry=0.
   - in0=4, in1=12, op=001 → out=-8, carry=1, neg=1, ovf=0.
5. Logic and illegal ops, with in0=0x55, in1=0xF0:
   - op=010 → 0x50.
   - op=011 → 0xF5 (neg=1).
   - op=100 → 0xA5 (neg=1).
   - op=101 → 0x00, flags=0b0001.
6. Reset mid-stream. Assert rst while rsp_valid=1 and rsp_ready=0. Required: rsp_valid=0 and op_count=0 immediately, without waiting for an edge. After release, with reqs 2 and 0 valid, requester 0 is granted first.
